// File: rtl/q1_sr_latch.sv
// Clocked model of two active-high SR latches: a plain 2-input NOR latch (A) and a
// 3-input NOR latch (B) whose set/reset are gated by en_s/en_r. Outputs are decoded from flops.
module q1_sr_latch (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    input  logic en_s,
    input  logic en_r,
    output logic q2,
    output logic qb2,
    output logic q3,
    output logic qb3,
    output logic inv2,
    output logic inv3
);

    typedef enum logic [1:0] {
        StReset  = 2'd0,
        StSet    = 2'd1,
        StForbid = 2'd2
    } latch_st_e;

    latch_st_e a_q, a_d;
    latch_st_e b_q, b_d;

    logic se, re;

    // Forbidden released with no request resolves to reset; the gate race is not modelled.
    function automatic latch_st_e latch_next(input latch_st_e cur, input logic set_req,
                                             input logic rst_req);
        latch_st_e nxt;
        nxt = cur;
        case ({set_req, rst_req})
            2'b10:   nxt = StSet;
            2'b01:   nxt = StReset;
            2'b11:   nxt = StForbid;
            default: nxt = (cur == StForbid) ? StReset : cur;
        endcase
        return nxt;
    endfunction

    always_comb begin
        se  = s & en_s;
        re  = r & en_r;
        a_d = latch_next(a_q, s, r);
        b_d = latch_next(b_q, se, re);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= StReset;
            b_q <= StReset;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    always_comb begin
        q2   = (a_q == StSet);
        qb2  = (a_q == StReset);
        inv2 = (a_q == StForbid);
        q3   = (b_q == StSet);
        qb3  = (b_q == StReset);
        inv3 = (b_q == StForbid);
    end

endmodule

// File: tb/tb_q1_sr_latch.sv
// Directed bench for q1_sr_latch: each step applies inputs for one edge and checks all
// six outputs, packed as {q2,qb2,inv2,q3,qb3,inv3}, against hand-computed values.
module tb_q1_sr_latch;

    logic clk = 1'b0;
    logic rst, s, r, en_s, en_r;
    logic q2, qb2, q3, qb3, inv2, inv3;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] RR = 6'b010_010;
    localparam logic [5:0] SS = 6'b100_100;
    localparam logic [5:0] FF = 6'b001_001;

    q1_sr_latch dut (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .r    (r),
        .en_s (en_s),
        .en_r (en_r),
        .q2   (q2),
        .qb2  (qb2),
        .q3   (q3),
        .qb3  (qb3),
        .inv2 (inv2),
        .inv3 (inv3)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic rst_v, input logic s_v, input logic r_v,
                        input logic es_v, input logic er_v, input logic [5:0] exp);
        logic [5:0] obs;
        rst  = rst_v;
        s    = s_v;
        r    = r_v;
        en_s = es_v;
        en_r = er_v;
        @(posedge clk);
        #1;
        obs = {q2, qb2, inv2, q3, qb3, inv3};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b required %b", tag, obs, exp);
        end
        // Pairwise equivalence of the variants whenever both gates are open.
        if (es_v && er_v && !rst_v) begin
            tests++;
            assert ({q2, qb2, inv2} === {q3, qb3, inv3}) else begin
                fails++;
                $error("FAIL %s_a_eq_b: got A=%b B=%b required equal", tag,
                       {q2, qb2, inv2}, {q3, qb3, inv3});
            end
        end
    endtask

    initial begin
        rst = 1'b1; s = 1'b0; r = 1'b0; en_s = 1'b1; en_r = 1'b1;

        step("reset",        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, RR);
        step("rst_r",        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, RR);
        step("rst_hold",     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RR);
        step("set",          1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SS);
        step("set_hold1",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SS);
        step("set_hold2",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SS);
        step("set_hold3",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SS);
        step("forbid",       1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FF);
        step("forbid_rel",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RR);

        step("seq0_01",      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, RR);
        step("seq1_10",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SS);
        step("seq2_01",      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, RR);
        step("seq3_11",      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FF);
        step("seq4_01",      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, RR);
        step("seq5_10",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SS);
        step("seq6_11",      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FF);
        step("seq7_10",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SS);
        step("seq8_11",      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FF);
        step("seq_rel_00",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RR);

        // Gated variant B diverges from A.
        step("gate_s_off",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b100_010);
        step("gate_sync",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SS);
        step("gate_r_off",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b010_100);
        step("gate_r_off11", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b001_100);
        step("gate_s_off11", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b001_010);

        // Reset overrides pending set and forbidden state.
        step("pre_rst_set",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SS);
        step("rst_over_set", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, RR);
        step("post_rst_set", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SS);
        step("pre_rst_forb", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FF);
        step("rst_over_frb", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, RR);
        step("post_rst_hld", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RR);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
